// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table and encode helper for the BCD display path.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied downstream.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b100_0000;

  // Codes 10-15 are not BCD; they show a dash so corrupted data is visible.
  localparam logic [SEG_W-1:0] SEG_GLYPH [16] = '{
    7'b011_1111,  // 0
    7'b000_0110,  // 1
    7'b101_1011,  // 2
    7'b100_1111,  // 3
    7'b110_0110,  // 4
    7'b110_1101,  // 5
    7'b111_1101,  // 6
    7'b000_0111,  // 7
    7'b111_1111,  // 8
    7'b110_1111,  // 9
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

  function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational nibble-to-segment decoder with a blanking override.
// The output is active-high; the caller applies board polarity.
module bcd_seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nibble,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    if (!i_blank) begin
      o_seg_c = seg7_encode(i_nibble);
    end
  end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed scanner for a packed-BCD value on a common-anode 7-segment
// display: tear-free loading, leading-zero blanking, whole-display blinking.
module bcd_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 5,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 50,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
  localparam int unsigned TICK_W  = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic        INV     = (ACTIVE_LOW != 0);

  logic [TICK_W-1:0]     r_tick_cnt;
  logic [IDX_W-1:0]      r_digit_idx;
  logic [BCD_W-1:0]      r_shadow;
  logic [BCD_W-1:0]      r_disp;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_phase;

  logic                  w_tick_last;
  logic                  w_idx_last;
  logic                  w_frame_wrap;
  logic                  w_blink_last;
  logic                  w_blink_dark;
  logic                  w_upper_zero;
  logic [NUM_DIGITS-1:0] w_blank_vec;
  logic [NUM_DIGITS-1:0] w_an_onehot;
  logic [3:0]            w_nibble;
  logic                  w_blank_sel;
  logic                  w_dp_sel;
  logic [SEG_W-1:0]      w_seg_pat;

  assign w_tick_last  = (r_tick_cnt == TICK_W'(REFRESH_DIV - 1));
  assign w_idx_last   = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_frame_wrap = w_tick_last && w_idx_last;
  assign w_blink_last = (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1));
  assign w_blink_dark = blink_en && r_blink_phase;

  // Dwell counter and digit pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_tick_last) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= w_idx_last ? '0 : r_digit_idx + IDX_W'(1);
    end else begin
      r_tick_cnt  <= r_tick_cnt + TICK_W'(1);
    end
  end

  // disp only follows shadow at a frame boundary, so one frame never mixes values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_disp   <= '0;
    end else begin
      if (load) begin
        r_shadow <= bcd_in;
      end
      if (w_frame_wrap) begin
        r_disp <= r_shadow;
      end
    end
  end

  // Blink runs on frame count regardless of blink_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_wrap) begin
      if (w_blink_last) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Leading-zero map (top digit down) and mux of the active digit
  always_comb begin
    w_upper_zero = 1'b1;
    w_blank_vec  = '0;
    w_an_onehot  = '0;
    w_nibble     = '0;
    w_blank_sel  = 1'b0;
    w_dp_sel     = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero   = w_upper_zero && (r_disp[4*k +: 4] == 4'd0);
      w_blank_vec[k] = blank_lz && w_upper_zero && (k != 0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_digit_idx == IDX_W'(k)) begin
        w_nibble       = r_disp[4*k +: 4];
        w_blank_sel    = w_blank_vec[k];
        w_dp_sel       = dp_mask[k];
        w_an_onehot[k] = 1'b1;
      end
    end
  end

  bcd_seg7_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank_sel),
    .o_seg_c  (w_seg_pat)
  );

  // Board-facing register; polarity is applied only here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg         <= {SEG_W{INV}};
      dp          <= INV;
      an          <= {NUM_DIGITS{INV}};
      frame_start <= 1'b0;
    end else begin
      seg         <= w_seg_pat ^ {SEG_W{INV}};
      dp          <= w_dp_sel ^ INV;
      an          <= (w_blink_dark ? '0 : w_an_onehot) ^ {NUM_DIGITS{INV}};
      frame_start <= w_frame_wrap;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Randomized bench for bcd_seg7_scanner against an edge-count reference model.
module tb_bcd_seg7_scanner;

  localparam int unsigned ND  = 5;
  localparam int unsigned DIV = 4;
  localparam int unsigned BF  = 2;
  localparam int unsigned FR  = DIV * ND;

  logic          clk = 1'b0;
  logic          reset;
  logic [19:0]   bcd_in;
  logic          load;
  logic          blank_lz;
  logic          blink_en;
  logic [4:0]    dp_mask;
  logic [6:0]    seg;
  logic          dp;
  logic [4:0]    an;
  logic          frame_start;

  always #5 clk = ~clk;

  bcd_seg7_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (DIV),
    .BLINK_FRAMES (BF),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bcd_in      (bcd_in),
    .load        (load),
    .blank_lz    (blank_lz),
    .blink_en    (blink_en),
    .dp_mask     (dp_mask),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int unsigned n_edges;
  logic [19:0] m_shadow;
  logic [19:0] m_disp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [4:0]  e_an;
  logic        e_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  endfunction

  // Outputs after edge n reflect digit floor((n-1)/DIV) mod ND of the value
  // latched at the last frame boundary; boundaries fall on every FR-th edge.
  task automatic model_edge();
    int unsigned prev;
    int unsigned idx;
    int unsigned wraps;
    logic [3:0]  nib;
    logic        blank;
    n_edges++;
    prev  = n_edges - 1;
    idx   = (prev / DIV) % ND;
    wraps = prev / FR;
    nib   = m_disp[4*idx +: 4];
    blank = blank_lz && (idx != 0) && ((m_disp >> (4*idx)) == 20'd0);
    e_seg = ~(blank ? 7'h00 : glyph(nib));
    e_dp  = ~dp_mask[idx];
    e_an  = (blink_en && ((wraps / BF) % 2 == 1)) ? 5'h1F : ~(5'b00001 << idx);
    e_fs  = (n_edges % FR == 0);
    if (n_edges % FR == 0) m_disp = m_shadow;
    if (load) m_shadow = bcd_in;
  endtask

  task automatic step(input logic ld, input logic [19:0] val);
    @(negedge clk);
    load   = ld;
    bcd_in = val;
    @(posedge clk);
    model_edge();
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("an",  32'(an),  32'(e_an));
    check("dp",  32'(dp),  32'(e_dp));
    check("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_an"},  32'(an),  32'h1F);
    check({tag, "_dp"},  32'(dp),  32'h1);
    check({tag, "_fs"},  32'(frame_start), 32'h0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    load     = 1'b0;
    reset    = 1'b0;
    n_edges  = 0;
    m_shadow = '0;
    m_disp   = '0;
  endtask

  // Mid-digit async reset: outputs must go dark before any further clock edge
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    check_dark("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_dark("rst_hold");
    release_reset();
  endtask

  function automatic logic [19:0] rand_bcd();
    logic [19:0] v;
    int unsigned keep;
    v = '0;
    for (int d = 0; d < 5; d++) begin
      if ($urandom_range(0, 9) == 0) v[4*d +: 4] = 4'($urandom_range(10, 15));
      else                           v[4*d +: 4] = 4'($urandom_range(0, 9));
    end
    keep = $urandom_range(1, 5);
    for (int d = 0; d < 5; d++) begin
      if (d >= int'(keep)) v[4*d +: 4] = 4'd0;
    end
    return v;
  endfunction

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    bcd_in   = '0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    dp_mask  = '0;
    #3;
    check_dark("rst_init");
    release_reset();

    // Plain scan of 12345
    step(1'b1, 20'h12345);
    repeat (60) step(1'b0, '0);

    // Leading-zero blanking, including value zero
    blank_lz = 1'b1;
    step(1'b1, 20'h00042);
    repeat (45) step(1'b0, '0);
    step(1'b1, 20'h00000);
    repeat (45) step(1'b0, '0);
    blank_lz = 1'b0;

    // Mid-frame load must not tear the current frame
    step(1'b1, 20'h11111);
    repeat (45) step(1'b0, '0);
    while (n_edges % FR != 7) step(1'b0, '0);
    step(1'b1, 20'h99999);
    repeat (40) step(1'b0, '0);

    // Load exactly on the frame-wrap edge
    while ((n_edges + 1) % FR != 0) step(1'b0, '0);
    step(1'b1, 20'h54321);
    repeat (45) step(1'b0, '0);

    // Illegal nibble and decimal point
    dp_mask = 5'b00100;
    step(1'b1, 20'h00A00);
    repeat (45) step(1'b0, '0);

    // Blink on, then off
    blink_en = 1'b1;
    repeat (200) step(1'b0, '0);
    blink_en = 1'b0;
    repeat (100) step(1'b0, '0);

    // Random mix of values, loads and control inputs
    repeat (30) begin
      blank_lz = 1'($urandom_range(0, 1));
      blink_en = 1'($urandom_range(0, 1));
      dp_mask  = 5'($urandom);
      step(1'b1, rand_bcd());
      repeat ($urandom_range(3, 40)) step(($urandom_range(0, 15) == 0), rand_bcd());
    end

    // Reset in the middle of a digit, then recovery
    blank_lz = 1'b0;
    blink_en = 1'b0;
    dp_mask  = 5'b00001;
    while (n_edges % DIV != 1) step(1'b0, '0);
    mid_reset();
    repeat (30) step(1'b0, '0);
    step(1'b1, 20'h31415);
    repeat (45) step(1'b0, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
